program_loader: RTL and testbench
=================================

# program_loader

Boot-time loader that sits directly upstream of the pipelined processor's fetch stage. It receives a framed program as a byte stream, assembles little-endian 32-bit instruction words, and writes them into instruction memory through its write port. It holds the core in reset until the whole frame passes its checksum, then releases it.

## Interface
- ADDR_WIDTH, 9, instruction memory word-address width; also the PC width.
- TIMEOUT_CYCLES, 65535, maximum idle cycles between bytes inside a frame.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; one clock domain.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  held high until the load succeeds; ORed with reset at the core.
- done  out  1  load complete and checksum good.
- error  out  1  frame rejected; sticky until reset.

## Operation
- Frame format: N_lo, N_hi (16-bit word count N, little-endian), then 4·N payload bytes (each word LSB first), then 1 checksum byte equal to the XOR of all payload bytes.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- rx_ready = 1 in HDR_LO, HDR_HI, PAYLOAD and CHECK; otherwise 0.
- State machine:
  - HDR_LO → HDR_HI on accept.
  - HDR_HI → PAYLOAD on accept if 1 ≤ N ≤ 2^ADDR_WIDTH; otherwise → ERROR.
  - PAYLOAD: a 2-bit byte counter shifts bytes into the assembler. On the 4th byte, register the word and pulse imem_we. The word index starts at 0 and increments after each write. → CHECK after word N−1.
  - CHECK → RUN if the byte equals the XOR accumulator; otherwise → ERROR.
  - RUN: done = 1, cpu_reset = 0. Terminal until reset.
  - ERROR: error = 1, cpu_reset = 1. Terminal until reset.
- Timeout: in HDR_HI, PAYLOAD or CHECK, if TIMEOUT_CYCLES consecutive cycles pass with no accepted byte → ERROR. HDR_LO never times out.
- Bytes presented in RUN or ERROR are ignored (rx_ready = 0).
- The XOR accumulator and the index are cleared in HDR_LO.
- Arithmetic: N is held in ADDR_WIDTH+1 bits after range check. The index is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH fills memory without wrap.

## Timing
- Reset values: state HDR_LO, rx_ready 1 (first cycle after reset), imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, error 0, counters 0.
- 4th byte of word k accepted at edge t → imem_we = 1, imem_addr = k, imem_wdata valid during cycle t+1 only. Memory captures it at edge t+1.
- All outputs are registered except rx_ready, which is decoded from state.
- No back-to-back hazard: one byte per cycle max gives at least 4 cycles between writes.
- Last payload byte at edge t → state CHECK and rx_ready = 1 in cycle t+1. A checksum byte in cycle t+1 is legal and coincides with the final imem_we pulse.
- Checksum accepted at edge t → done = 1 and cpu_reset = 0 from cycle t+1. The core fetches address 0 at the next edge.
- Error detected at edge t → error = 1 from cycle t+1.
- Reset mid-frame → return to reset values next cycle. Memory contents already written are not cleared.

## Structure
- loader_pkg:
  - state enum (HDR_LO, HDR_HI, PAYLOAD, CHECK, RUN, ERROR);
  - HDR_BYTES = 2, WORD_BYTES = 4.
- Sub-module word_assembler: byte shift register plus 2-bit counter. Emits a 32-bit word and a one-cycle word_valid.
- The top level holds the FSM, word index, XOR accumulator and timeout counter.

## Test plan
- Good load: bytes 02 00 13 00 A0 00 EF BE AD DE 91 → writes 0x00A00013 @0, 0xDEADBEEF @1; done = 1, cpu_reset = 0 one cycle after 0x91.
- Bad checksum: same frame with final byte 0x90 → no done, error = 1 and cpu_reset = 1 one cycle after; later bytes see rx_ready = 0.
- Header bounds:
  - N = 0 → error after byte 2, no imem_we.
  - N = 513 (01 02) → error.
  - N = 512 → 512 writes, addresses 0..511, last address 0x1FF.
- Backpressure gaps: rx_valid toggled randomly with idle ≤ TIMEOUT_CYCLES−1 → identical writes and done. An idle of TIMEOUT_CYCLES mid-payload → error.
- Reset mid-payload: after 5 payload bytes, pulse reset 1 cycle → outputs at reset values. A fresh valid frame then loads correctly.
- Post-done input: bytes driven after done → rx_ready = 0, no imem_we, done remains 1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
//   state_e      : loader FSM states
//   HDR_BYTES    : bytes in the frame header (16-bit word count)
//   WORD_BYTES   : bytes per instruction word
//   is_last_byte : true when the byte counter points at the final byte of a word
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    PAYLOAD,
    CHECK,
    RUN,
    ERROR
  } state_e;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  function automatic logic is_last_byte(input logic [1:0] cnt);
    return cnt == 2'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Assembles little-endian 32-bit words from a byte stream.
//   clk, reset    : clock, synchronous active-high reset
//   clear_i       : restart at byte 0 of a word
//   byte_valid_i  : byte_i is consumed this cycle
//   byte_i        : incoming byte (first byte of a word is the LSB)
//   byte_cnt_o    : position of the next byte within the current word
//   word_o        : last completed word (registered)
//   word_valid_o  : one-cycle pulse in the cycle after a word completes
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  byte_cnt_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic        word_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (clear_i) begin
        cnt_q <= '0;
      end else if (byte_valid_i) begin
        // Bytes enter at the top so the first byte ends up in bits [7:0].
        if (is_last_byte(cnt_q)) begin
          word_q       <= {byte_i, shift_q};
          word_valid_q <= 1'b1;
        end
        shift_q <= {byte_i, shift_q[23:8]};
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

  assign byte_cnt_o   = cnt_q;
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream (16-bit word count,
// little-endian payload words, XOR checksum), writes the words into
// instruction memory and keeps the core in reset until the frame checks out.
//   clk, reset        : clock, synchronous active-high reset
//   rx_data, rx_valid : incoming byte stream
//   rx_ready          : byte accepted when rx_valid && rx_ready
//   imem_we/addr/wdata: instruction memory write port (registered)
//   cpu_reset         : high until a frame loads with a good checksum
//   done              : load complete, checksum good
//   error             : frame rejected (bad count, checksum or timeout); sticky
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH + 1)'(1);

  state_e state_q, state_d;

  logic [7:0]             n_lo_q;
  logic [ADDR_WIDTH:0]    n_q;
  logic [ADDR_WIDTH:0]    idx_q;
  logic [7:0]             xor_q;
  logic [TW-1:0]          timer_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   done_q, error_q, cpu_reset_q;

  logic                   accept;
  logic                   timed_state;
  logic                   timeout;
  logic                   word_end;
  logic                   n_ok;
  logic [8*HDR_BYTES-1:0] n_hdr;

  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic        asm_valid;

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (state_q == HDR_LO),
    .byte_valid_i (accept && (state_q == PAYLOAD)),
    .byte_i       (rx_data),
    .byte_cnt_o   (byte_cnt),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  // Output / decode logic
  always_comb begin
    rx_ready    = state_q inside {HDR_LO, HDR_HI, PAYLOAD, CHECK};
    accept      = rx_valid && rx_ready;
    timed_state = state_q inside {HDR_HI, PAYLOAD, CHECK};
    timeout     = timed_state && !accept && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    word_end    = (state_q == PAYLOAD) && accept && is_last_byte(byte_cnt);
    n_hdr       = {rx_data, n_lo_q};
    n_ok        = (n_hdr != '0) && (32'(n_hdr) <= (32'd1 << ADDR_WIDTH));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_LO: if (accept) state_d = HDR_HI;
      HDR_HI: begin
        if (timeout)     state_d = ERROR;
        else if (accept) state_d = n_ok ? PAYLOAD : ERROR;
      end
      PAYLOAD: begin
        if (timeout)                                  state_d = ERROR;
        else if (word_end && (idx_q == n_q - IDX_ONE)) state_d = CHECK;
      end
      CHECK: begin
        if (timeout)     state_d = ERROR;
        else if (accept) state_d = (rx_data == xor_q) ? RUN : ERROR;
      end
      default: state_d = state_q;
    endcase
  end

  // State register with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR_LO;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      done_q      <= (state_d == RUN);
      error_q     <= (state_d == ERROR);
      cpu_reset_q <= (state_d != RUN);
    end
  end

  // Datapath: header, word index, checksum accumulator, idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      xor_q   <= '0;
      timer_q <= '0;
      addr_q  <= '0;
    end else begin
      if (accept || !timed_state) timer_q <= '0;
      else                        timer_q <= timer_q + TW'(1);

      unique case (state_q)
        HDR_LO: begin
          xor_q <= '0;
          idx_q <= '0;
          if (accept) n_lo_q <= rx_data;
        end
        HDR_HI: begin
          if (accept) n_q <= n_hdr[ADDR_WIDTH:0];
        end
        PAYLOAD: begin
          if (accept) xor_q <= xor_q ^ rx_data;
          // Address is latched alongside the word so both appear in the same cycle.
          if (word_end) begin
            addr_q <= idx_q[ADDR_WIDTH-1:0];
            idx_q  <= idx_q + IDX_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = asm_valid;
  assign imem_addr  = addr_q;
  assign imem_wdata = asm_word;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected memory writes,
// a monitor pops and compares on every imem_we; status outputs are checked
// directly after each relevant byte.
module tb_program_loader;

  localparam int unsigned AW = 9;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [AW-1:0] last_addr = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   imem_addr, imem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
          chk("wr_data", imem_wdata, mon_e.data);
          last_addr = imem_addr;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input int unsigned cycles);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
  endtask

  task automatic send_list(input logic [7:0] bl[$], input int unsigned gapmax);
    foreach (bl[i]) send_byte(bl[i], (gapmax == 0) ? 0 : $urandom_range(0, gapmax));
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    idle();
    repeat (4) @(posedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic push_good_words();
    exp_q.push_back('{addr: 9'd0, data: 32'h00A0_0013});
    exp_q.push_back('{addr: 9'd1, data: 32'hDEAD_BEEF});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"},  32'(rx_ready),   32'd1);
    chk({tag, "_we"},        32'(imem_we),    32'd0);
    chk({tag, "_addr"},      32'(imem_addr),  32'd0);
    chk({tag, "_wdata"},     imem_wdata,      32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset),  32'd1);
    chk({tag, "_done"},      32'(done),       32'd0);
    chk({tag, "_error"},     32'(error),      32'd0);
  endtask

  logic [7:0] good_body[$] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'hA0, 8'h00,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] big[$];
  logic [7:0] cs;
  logic [31:0] w;

  initial begin
    // Reset state
    apply_reset(2);
    check_reset_outputs("rst");

    // Good load
    push_good_words();
    send_list(good_body, 0);
    #1;
    chk("good_pre_cs_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("good_pre_cs_done",      32'(done),      32'd0);
    chk("good_check_ready",      32'(rx_ready),  32'd1);
    send_byte(8'h91, 0);
    #1;
    chk("good_done",      32'(done),      32'd1);
    chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("good_error",     32'(error),     32'd0);
    drain("good_drain");

    // Bytes after done are ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'(8'h55 + i);
      #1;
      chk("post_done_ready", 32'(rx_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("post_done_done", 32'(done), 32'd1);
    end
    drain("post_done_drain");

    // Bad checksum
    apply_reset(1);
    push_good_words();
    send_list(good_body, 0);
    send_byte(8'h90, 0);
    #1;
    chk("badcs_error",     32'(error),     32'd1);
    chk("badcs_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("badcs_done",      32'(done),      32'd0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    #1;
    chk("badcs_ready", 32'(rx_ready), 32'd0);
    drain("badcs_drain");

    // N = 0
    apply_reset(1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    #1;
    chk("n0_error", 32'(error), 32'd1);
    drain("n0_drain");

    // N = 513
    apply_reset(1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    #1;
    chk("n513_error", 32'(error), 32'd1);
    drain("n513_drain");

    // N = 512 fills memory 0..511
    apply_reset(1);
    big.delete();
    big.push_back(8'h00);
    big.push_back(8'h02);
    cs = '0;
    for (int i = 0; i < 512; i++) begin
      w = {8'(i), 8'hC3, 8'(i >> 1), 8'(~i)};
      exp_q.push_back('{addr: 9'(i), data: w});
      for (int b = 0; b < 4; b++) begin
        big.push_back(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
    big.push_back(cs);
    send_list(big, 0);
    #1;
    chk("n512_done", 32'(done), 32'd1);
    drain("n512_drain");
    chk("n512_last_addr", 32'(last_addr), 32'h1FF);

    // Backpressure gaps below the timeout, including the maximum legal idle
    apply_reset(1);
    push_good_words();
    send_list(good_body, TO - 1);
    send_byte(8'h91, TO - 1);
    #1;
    chk("gap_done",  32'(done),  32'd1);
    chk("gap_error", 32'(error), 32'd0);
    drain("gap_drain");

    // Idle of TO-1 cycles is fine, TO cycles mid-payload is an error
    apply_reset(1);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    idle();
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("timeout_edge_error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_error", 32'(error), 32'd1);
    drain("timeout_drain");

    // Reset mid-payload, then a fresh frame
    apply_reset(1);
    exp_q.push_back('{addr: 9'd0, data: 32'h00A0_0013});
    for (int i = 0; i < 7; i++) send_byte(good_body[i], 0);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    push_good_words();
    send_list(good_body, 0);
    send_byte(8'h91, 0);
    #1;
    chk("midrst_done",      32'(done),      32'd1);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd0);
    drain("midrst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
